// File: rtl/image_reader.sv
// Raster-scan reader: snapshots a WIDTH x HEIGHT bitmap on start and streams it
// one pixel per accepted valid/ready beat, with x/y coordinates and first/last markers.
module image_reader #(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 4,
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH*HEIGHT-1:0]   image,
    input  logic                      ready,
    output logic                      pixel,
    output logic [XW-1:0]             x,
    output logic [YW-1:0]             y,
    output logic                      valid,
    output logic                      first,
    output logic                      last,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    state_t                    state_q, state_d;
    logic [XW-1:0]             x_q, x_d;
    logic [YW-1:0]             y_q, y_d;
    logic [WIDTH*HEIGHT-1:0]   snap_q, snap_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            snap_q  <= snap_d;
        end
    end

    // The snapshot is consumed as a shift register in raster order, so bit 0
    // always holds the pixel at the current (x,y).
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        snap_d  = snap_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = image;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (ready) begin
                    snap_d = snap_q >> 1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = DONE;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign valid = (state_q == SCAN);
    assign busy  = (state_q == SCAN);
    assign done  = (state_q == DONE);
    assign pixel = valid & snap_q[0];
    assign x     = x_q;
    assign y     = y_q;
    assign first = valid && (x_q == '0) && (y_q == '0);
    assign last  = valid && (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: doc/image_reader.md
IMAGE_READER -- requirements
Module: image_reader

Interface
REQ-001 Parameter WIDTH, default 4, pixels per row (>=1).
REQ-002 Parameter HEIGHT, default 4, rows per frame (>=1).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset; sampled on rising clk edge.
REQ-005 Port start  input  1  request one frame scan; sampled in IDLE only.
REQ-006 Port image  input  WIDTH*HEIGHT  bitmap; bit index y*WIDTH+x holds pixel (x,y).
REQ-007 Port ready  input  1  downstream accepts the current pixel when high with valid.
REQ-008 Port pixel  output  1  pixel value of current beat.
REQ-009 Port x  output  XW  column of current beat; XW = max(1, clog2(WIDTH)).
REQ-010 Port y  output  YW  row of current beat; YW = max(1, clog2(HEIGHT)).
REQ-011 Port valid  output  1  current beat (pixel, x, y, first, last) is valid.
REQ-012 Port first  output  1  high on the beat for (0,0).
REQ-013 Port last  output  1  high on the beat for (WIDTH-1,HEIGHT-1).
REQ-014 Port busy  output  1  high in SCAN state.
REQ-015 Port done  output  1  one-cycle pulse after final beat is accepted.

Function
REQ-016 FSM states IDLE, SCAN, DONE; reset state IDLE.
REQ-017 IDLE: start=1 -> snapshot image into internal register, x=0, y=0, go SCAN next cycle.
REQ-018 Frame data SHALL come only from the snapshot; image changes during SCAN have no effect on output.
REQ-019 SCAN: valid=1 every cycle; pixel = snapshot[y*WIDTH+x].
REQ-020 Handshake: beat transfers on rising edge with valid=1 and ready=1; no transfer otherwise.
REQ-021 While valid=1 and ready=0, pixel, x, y, first, last SHALL hold stable.
REQ-022 On transfer with x<WIDTH-1: x increments, y unchanged.
REQ-023 On transfer with x=WIDTH-1 and y<HEIGHT-1: x wraps to 0, y increments.
REQ-024 On transfer of last beat: go DONE; x,y return to 0.
REQ-025 Throughput: with ready held high, one beat per cycle; WIDTH*HEIGHT beats back-to-back, no bubbles.
REQ-026 Latency: first beat valid exactly 1 cycle after the cycle start is sampled in IDLE.
REQ-027 DONE: done=1, valid=0 for exactly one cycle, then IDLE unconditionally.
REQ-028 start in SCAN or DONE SHALL be ignored (no restart, no snapshot update).
REQ-029 start held high continuously: new frame begins from the IDLE cycle after DONE (one idle cycle between frames).
REQ-030 WIDTH=1 and/or HEIGHT=1 SHALL work: first and last coincide when WIDTH*HEIGHT=1.
REQ-031 valid, busy, done, first, last SHALL be 0 in IDLE; pixel, x, y are 0 in IDLE.

Reset
REQ-032 reset=1 at a clock edge forces IDLE, x=0, y=0, snapshot=0; next cycle valid=0, busy=0, done=0, pixel=0, first=0, last=0.
REQ-033 reset has priority over start and ready in the same cycle.
REQ-034 reset mid-SCAN SHALL abort the frame with no done pulse; a later start rescans from (0,0).

Verification (WIDTH=4, HEIGHT=4 unless stated)
REQ-035 image=16'h0001, start pulse, ready=1 -> 16 consecutive beats; pixel=1 only at (0,0) with first=1; last=1 at (3,3); done pulses 1 cycle after beat 16.
REQ-036 image=16'h8421, ready toggling 1/0 every cycle -> beats 0..15 in raster order, pixel=1 at (0,0),(1,1),(2,2),(3,3); outputs stable during every ready=0 cycle; 32 SCAN cycles total.
REQ-037 start with image=16'hFFFF, then image=16'h0000 one cycle later -> all 16 beats pixel=1.
REQ-038 start pulsed again at beat 5 -> ignored; frame completes with 16 beats and exactly one done pulse.
REQ-039 reset asserted at beat 7 -> valid=0 next cycle, no done; subsequent start yields full 16-beat frame from (0,0).
REQ-040 WIDTH=1, HEIGHT=1, image=1'b1 -> single beat with pixel=1, first=1, last=1, x=0, y=0, then done pulse.
